// File: rtl/tcp_tx_arbiter_if.sv
// Handshake bundle shared by the TCP segment requesters, the TX arbiter and the
// TX segment builder.
interface tcp_tx_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int FLAGS_W = 6
);
  logic [N_REQ-1:0]         req_vld;
  logic [N_REQ*FLAGS_W-1:0] req_flags;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         done;
  logic                     tx_start;
  logic [FLAGS_W-1:0]       tx_flags;
  logic                     tx_done_in;
  logic                     tx_busy;

  // Requester/builder side: raises requests and reports builder completion.
  modport master (
    output req_vld,
    output req_flags,
    output tx_done_in,
    input  grant,
    input  done,
    input  tx_start,
    input  tx_flags,
    input  tx_busy
  );

  // Arbiter side.
  modport slave (
    input  req_vld,
    input  req_flags,
    input  tx_done_in,
    output grant,
    output done,
    output tx_start,
    output tx_flags,
    output tx_busy
  );
endinterface

// File: rtl/tcp_tx_arbiter.sv
// Shares one TCP TX segment builder between RST, handshake, FIN and data requesters:
// strict priority for the RST path, round-robin for the rest, watchdog per frame.
module tcp_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int FLAGS_W        = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  tcp_tx_arbiter_if.slave bus,
  output logic            err_timeout,
  output logic [15:0]     frame_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } state_t;

  state_t             state_q, state_n;
  logic [PTR_W-1:0]   idx_q, idx_n;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_n;
  logic [TMR_W-1:0]   timer_q, timer_n;
  logic [FLAGS_W-1:0] flags_q, flags_n;
  logic [N_REQ-1:0]   grant_q, grant_n;
  logic [N_REQ-1:0]   done_q, done_n;
  logic               start_q, start_n;
  logic               err_q, err_n;
  logic [15:0]        frame_cnt_q, frame_cnt_n;

  logic               any_req;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand_idx;
  int                 cand;
  logic [FLAGS_W-1:0] win_flags;
  logic [N_REQ-1:0]   win_onehot;
  logic [N_REQ-1:0]   idx_onehot;

  // Scanning from the far end backwards leaves the first hit after rr_ptr in win_idx;
  // index 0 is never a round-robin candidate because it already has strict priority.
  always_comb begin
    any_req  = |bus.req_vld;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    if (!bus.req_vld[0]) begin
      for (int i = N_REQ; i >= 1; i--) begin
        cand     = (int'(rr_ptr_q) + i) % N_REQ;
        cand_idx = PTR_W'(cand);
        if (cand != 0 && bus.req_vld[cand_idx]) begin
          win_idx = cand_idx;
        end
      end
    end
  end

  always_comb begin
    win_flags  = '0;
    win_onehot = '0;
    idx_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = (win_idx == PTR_W'(i));
      idx_onehot[i] = (idx_q == PTR_W'(i));
      if (win_idx == PTR_W'(i)) begin
        win_flags = bus.req_flags[i*FLAGS_W +: FLAGS_W];
      end
    end
  end

  // Pulse outputs are computed one cycle ahead so that they are registered and
  // line up with the state they belong to (grant/tx_start in ISSUE, done/err in GAP).
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    rr_ptr_n    = rr_ptr_q;
    timer_n     = timer_q;
    flags_n     = flags_q;
    grant_n     = '0;
    done_n      = '0;
    start_n     = 1'b0;
    err_n       = 1'b0;
    frame_cnt_n = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_n = ISSUE;
          idx_n   = win_idx;
          flags_n = win_flags;
          grant_n = win_onehot;
          start_n = 1'b1;
          timer_n = '0;
        end
      end
      ISSUE: begin
        state_n = WAIT;
        timer_n = timer_q + TMR_W'(1);
      end
      WAIT: begin
        // Completion beats the watchdog when both land on the same cycle.
        if (bus.tx_done_in) begin
          state_n     = GAP;
          done_n      = idx_onehot;
          frame_cnt_n = frame_cnt_q + 16'd1;
          if (idx_q != '0) begin
            rr_ptr_n = idx_q;
          end
        end else if (timer_q == TMR_LAST) begin
          state_n = GAP;
          err_n   = 1'b1;
        end else begin
          timer_n = timer_q + TMR_W'(1);
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rr_ptr_q    <= PTR_RST;
      timer_q     <= '0;
      flags_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      rr_ptr_q    <= rr_ptr_n;
      timer_q     <= timer_n;
      flags_q     <= flags_n;
      grant_q     <= grant_n;
      done_q      <= done_n;
      start_q     <= start_n;
      err_q       <= err_n;
      frame_cnt_q <= frame_cnt_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.tx_start = start_q;
  assign bus.tx_flags = flags_q;
  assign bus.tx_busy  = (state_q != IDLE);
  assign err_timeout  = err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: expected grants and completions go through a
// scoreboard queue and are checked when the arbiter produces them.
module tb_tcp_tx_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [5:0] flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_timeout;
  logic [15:0] frame_cnt;

  tcp_tx_arbiter_if #(.N_REQ(4), .FLAGS_W(6)) bus ();

  tcp_tx_arbiter #(
    .N_REQ(4),
    .FLAGS_W(6),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          pass_count = 0;
  int          check_count = 0;
  int          fail_count = 0;
  logic [15:0] ref_cnt = 16'd0;
  exp_t        exp_q[$];
  logic [3:0]  done_exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] vld, input logic [23:0] flags);
    bus.req_vld   = vld;
    bus.req_flags = flags;
  endtask

  task automatic expectGrant(input logic [3:0] g, input logic [5:0] f);
    exp_t e;
    e.grant = g;
    e.flags = f;
    exp_q.push_back(e);
  endtask

  // Leaves the caller at the falling edge inside the ISSUE cycle.
  task automatic waitGrant(output int cycles);
    exp_t e;
    bit   seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (bus.grant != 4'b0000) seen = 1'b1;
    end
    checkOutput("grant_seen", 32'(seen), 32'd1);
    e = exp_q.pop_front();
    checkOutput("grant", 32'(bus.grant), 32'(e.grant));
    checkOutput("tx_start", 32'(bus.tx_start), 32'd1);
    checkOutput("tx_flags", 32'(bus.tx_flags), 32'(e.flags));
    checkOutput("tx_busy", 32'(bus.tx_busy), 32'd1);
  endtask

  task automatic completeFrame(input int delay, input logic [3:0] who);
    repeat (delay) @(negedge clk);
    bus.tx_done_in = 1'b1;
    done_exp_q.push_back(who);
    @(negedge clk);
    bus.tx_done_in = 1'b0;
    checkOutput("done", 32'(bus.done), 32'(done_exp_q.pop_front()));
    checkOutput("no_err_on_done", 32'(err_timeout), 32'd0);
    ref_cnt = ref_cnt + 16'd1;
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(ref_cnt));
  endtask

  task automatic applyReset();
    bus.req_vld    = 4'b0000;
    bus.req_flags  = 24'h0;
    bus.tx_done_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    checkOutput("rst_tx_flags", 32'(bus.tx_flags), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    rst = 1'b1;
    ref_cnt = 16'd0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc;
    int          k;
    bit          seen_err;
    bit          seen_done;
    bit          stray;
    logic [3:0]  g;
    logic [5:0]  flg[4];
    logic [23:0] all_flags;
    int          tally[4];

    flg[0] = 6'b000100;
    flg[1] = 6'b010010;
    flg[2] = 6'b010000;
    flg[3] = 6'b010001;
    all_flags = {flg[3], flg[2], flg[1], flg[0]};

    // Single request from requester 2.
    applyReset();
    applyStimulus(4'b0100, {6'h00, 6'b010010, 6'h00, 6'h00});
    expectGrant(4'b0100, 6'b010010);
    waitGrant(cyc);
    checkOutput("grant_latency", 32'(cyc), 32'd1);
    applyStimulus(4'b0000, 24'h0);
    @(negedge clk);
    checkOutput("grant_pulse", 32'(bus.grant), 32'd0);
    checkOutput("start_pulse", 32'(bus.tx_start), 32'd0);
    checkOutput("flags_held", 32'(bus.tx_flags), 32'(6'b010010));
    completeFrame(4, 4'b0100);
    @(negedge clk);
    checkOutput("done_pulse", 32'(bus.done), 32'd0);
    checkOutput("idle_after_gap", 32'(bus.tx_busy), 32'd0);

    // Strict priority of requester 0, then round-robin once it drops out.
    applyReset();
    applyStimulus(4'b1111, all_flags);
    expectGrant(4'b0001, flg[0]);
    waitGrant(cyc);
    completeFrame(3, 4'b0001);
    expectGrant(4'b0001, flg[0]);
    waitGrant(cyc);
    checkOutput("next_grant_gap", 32'(cyc), 32'd2);
    applyStimulus(4'b1110, all_flags);
    completeFrame(3, 4'b0001);
    expectGrant(4'b0010, flg[1]);
    expectGrant(4'b0100, flg[2]);
    expectGrant(4'b1000, flg[3]);
    expectGrant(4'b0010, flg[1]);
    for (int i = 0; i < 4; i++) begin
      g = exp_q[0].grant;
      waitGrant(cyc);
      if (i == 3) applyStimulus(4'b0000, all_flags);
      completeFrame(3, g);
    end

    // Round-robin fairness over nine frames.
    applyReset();
    for (int i = 0; i < 4; i++) tally[i] = 0;
    applyStimulus(4'b1110, all_flags);
    for (int i = 0; i < 9; i++) begin
      g = 4'b0010 << (i % 3);
      expectGrant(g, flg[(i % 3) + 1]);
      waitGrant(cyc);
      for (int b = 0; b < 4; b++) if (bus.grant[b]) tally[b]++;
      if (i == 8) applyStimulus(4'b0000, all_flags);
      completeFrame(1, g);
    end
    checkOutput("tally_0", 32'(tally[0]), 32'd0);
    checkOutput("tally_1", 32'(tally[1]), 32'd3);
    checkOutput("tally_2", 32'(tally[2]), 32'd3);
    checkOutput("tally_3", 32'(tally[3]), 32'd3);

    // Watchdog: builder never answers.
    applyReset();
    applyStimulus(4'b0010, all_flags);
    expectGrant(4'b0010, flg[1]);
    waitGrant(cyc);
    applyStimulus(4'b0000, all_flags);
    k = 0;
    seen_err = 1'b0;
    seen_done = 1'b0;
    while (!seen_err && k < 1100) begin
      @(negedge clk);
      k++;
      if (err_timeout) seen_err = 1'b1;
      if (bus.done != 4'b0000) seen_done = 1'b1;
    end
    checkOutput("timeout_seen", 32'(seen_err), 32'd1);
    checkOutput("timeout_cycle", 32'(k), 32'd1024);
    checkOutput("timeout_no_done", 32'(seen_done), 32'd0);
    checkOutput("timeout_frame_cnt", 32'(frame_cnt), 32'(ref_cnt));
    @(negedge clk);
    checkOutput("err_pulse", 32'(err_timeout), 32'd0);
    checkOutput("busy_after_err_1", 32'(bus.tx_busy), 32'd0);
    @(negedge clk);
    checkOutput("busy_after_err_2", 32'(bus.tx_busy), 32'd0);

    // Completion on the exact timeout cycle wins over the watchdog.
    applyStimulus(4'b0010, all_flags);
    expectGrant(4'b0010, flg[1]);
    waitGrant(cyc);
    applyStimulus(4'b0000, all_flags);
    completeFrame(1023, 4'b0010);

    // Asynchronous reset in the middle of a frame.
    applyReset();
    applyStimulus(4'b0100, all_flags);
    expectGrant(4'b0100, flg[2]);
    waitGrant(cyc);
    applyStimulus(4'b1000, all_flags);
    completeFrame(2, 4'b0100);
    expectGrant(4'b1000, flg[3]);
    waitGrant(cyc);
    applyStimulus(4'b0000, all_flags);
    repeat (3) @(negedge clk);
    checkOutput("busy_before_reset", 32'(bus.tx_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_busy", 32'(bus.tx_busy), 32'd0);
    checkOutput("async_flags", 32'(bus.tx_flags), 32'd0);
    checkOutput("async_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ref_cnt = 16'd0;
    bus.tx_done_in = 1'b1;
    @(negedge clk);
    bus.tx_done_in = 1'b0;
    checkOutput("stray_done", 32'(bus.done), 32'd0);
    checkOutput("stray_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("stray_busy", 32'(bus.tx_busy), 32'd0);
    applyStimulus(4'b1110, all_flags);
    expectGrant(4'b0010, flg[1]);
    waitGrant(cyc);
    applyStimulus(4'b0000, all_flags);
    completeFrame(2, 4'b0010);

    // Counter wrap, plus a request raised and withdrawn during WAIT.
    applyReset();
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    ref_cnt = 16'hFFFE;
    applyStimulus(4'b0010, all_flags);
    expectGrant(4'b0010, flg[1]);
    waitGrant(cyc);
    applyStimulus(4'b0000, all_flags);
    @(negedge clk);
    applyStimulus(4'b0100, all_flags);
    @(negedge clk);
    applyStimulus(4'b0000, all_flags);
    completeFrame(2, 4'b0010);
    applyStimulus(4'b1000, all_flags);
    expectGrant(4'b1000, flg[3]);
    waitGrant(cyc);
    applyStimulus(4'b0000, all_flags);
    completeFrame(1, 4'b1000);
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.grant != 4'b0000) stray = 1'b1;
    end
    checkOutput("no_withdrawn_grant", 32'(stray), 32'd0);

    if (fail_count != 0) $display("[TB] FAIL tally: %0d comparisons failed", fail_count);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
